// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, FSM states and LFSR seed for mem_responder
package mem_pkg;

    localparam int LINE_W      = 128;
    localparam int LINE_ADDR_W = 28;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_lfsr8.sv
// rtl/mem_lfsr8.sv - 8-bit Galois LFSR (taps 8,6,5,4) used for latency jitter
// Ports: clk, proc_reset (sync, active-high, reloads seed),
//        advance (step one position), lfsr_q (current value).
module mem_lfsr8
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       proc_reset,
    input  logic       advance,
    output logic [7:0] lfsr_q
);

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (advance) begin
            // Right-shifting Galois form: the bit shifted out feeds taps 8,6,5,4.
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
        end
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - line-granular memory model with programmable response latency
// Ports: clk, proc_reset (sync, active-high), mem_read / mem_write requests,
//        mem_addr (line address), mem_wdata (write line),
//        mem_rdata (read line, valid with mem_ready), mem_ready (one-cycle done pulse).
// Optional: MEM_JITTER_EN adds 0..3 LFSR-driven extra busy cycles per request.
module mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   proc_reset,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [LINE_ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0]      mem_wdata,
    output logic [LINE_W-1:0]      mem_rdata,
    output logic                   mem_ready
);

    localparam int CNT_W = $clog2(LATENCY + 4);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    mem_state_t state_q, state_d;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic [LINE_W-1:0]     wdata_q, wdata_d;
    logic [LINE_W-1:0]     rdata_q;
    logic                  ready_q;

    logic [LINE_W-1:0]     mem_array [DEPTH];

    logic                  sample;
    logic                  enter_resp;
    logic [CNT_W-1:0]      load_val;
    logic [1:0]            jitter;

    // Upper address bits alias onto the same lines.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[LINE_ADDR_W-1:DEPTH_LOG2];

`ifdef MEM_JITTER_EN
    logic [7:0] lfsr_q;
    logic       unused_lfsr_bits;

    mem_lfsr8 u_lfsr (
        .clk        (clk),
        .proc_reset (proc_reset),
        .advance    (sample),
        .lfsr_q     (lfsr_q)
    );

    // The value current at the sample edge sets this request's extra delay.
    assign jitter           = lfsr_q[1:0];
    assign unused_lfsr_bits = ^lfsr_q[7:2];
`else
    assign jitter = 2'b00;
`endif

    assign load_val = CNT_W'(LATENCY - 1) + CNT_W'(jitter);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        sample     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    sample  = 1'b1;
                    idx_d   = mem_addr[DEPTH_LOG2-1:0];
                    wr_d    = mem_write;  // write wins over a simultaneous read
                    wdata_d = mem_wdata;
                    cnt_d   = load_val;
                    if (load_val == '0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // Counter holds remaining busy cycles; leaving on 1 makes the
                // total latency equal to the loaded value plus one.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // idx_d/wr_d/wdata_d already select the live inputs when RESP is entered
    // straight from IDLE, so the array access below covers LATENCY = 1 too.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            ready_q <= enter_resp;
            if (enter_resp && !wr_d) begin
                rdata_q <= mem_array[idx_d];
            end
        end
    end

    // No reset on the array: contents survive proc_reset.
    always_ff @(posedge clk) begin
        if (!proc_reset && enter_resp && wr_d) begin
            mem_array[idx_d] <= wdata_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the direct-mapped cache's line-refill/write-back interface. It accepts one 128-bit line read or write per request, holds it for a programmable latency, and answers with a one-cycle `mem_ready` pulse. It stands in for the slow main memory in simulation and FPGA bring-up, so the cache FSM sees realistic multi-cycle stalls.

## Interface
- `LATENCY`, default 4: cycles from request sample to `mem_ready`; legal range 1..15.
- `DEPTH_LOG2`, default 10: log2 of the number of stored lines.
- `clk`  input  1: single clock; all logic on posedge.
- `proc_reset`  input  1: synchronous, active-high reset.
- `mem_read`  input  1: line read request.
- `mem_write`  input  1: line write request.
- `mem_addr`  input  28: line address (word address >> 2).
- `mem_wdata`  input  128: write line.
- `mem_rdata`  output  128: read line; valid only while `mem_ready` = 1.
- `mem_ready`  output  1: one-cycle completion pulse.

## Operation
- **Reset**: state IDLE, `mem_ready` = 0, `mem_rdata` = 0, counter = 0. Array contents are not cleared and persist across reset.
- **Storage**: `2**DEPTH_LOG2` lines × 128 bits, indexed by `mem_addr[DEPTH_LOG2-1:0]`. Upper address bits alias (wrap modulo depth).
- **IDLE**: at a clock edge with `mem_read | mem_write` = 1:
  - latch addr, wdata and op;
  - load counter with `LATENCY-1`;
  - go to BUSY, or straight to RESP when `LATENCY` = 1.
- **Simultaneous read and write**: write wins; the read is ignored.
- **BUSY**: decrement counter each cycle; at 0 go to RESP. Request inputs are ignored. Dropping or changing them mid-operation has no effect; the latched request completes.
- **Transition into RESP**:
  - read: `mem_rdata` <= `array[idx]`;
  - write: `array[idx]` <= latched wdata; `mem_rdata` keeps its previous value.
- **RESP**: `mem_ready` = 1 for exactly one cycle, then IDLE. Request inputs are not sampled during RESP.
- **Turnaround**: the cache drops its request combinationally while `mem_ready` = 1 and changes state at the same edge. A request seen in the first IDLE cycle after RESP is therefore always new; this is the write-back → refill path.
- **Read-after-write**: a read of the same address issued right after a write returns the new data.
- **Reset mid-operation**: the pending request is discarded; no array write occurs; `mem_ready` stays 0.

## Timing
- Request present in cycle 0 (sampled at the end-of-cycle-0 edge) gives `mem_ready` high in cycle `LATENCY`, with `mem_rdata` valid in that same cycle.
- Back-to-back throughput: one request per `LATENCY`+1 cycles; the IDLE cycle after RESP is the sample cycle.
- `mem_ready` and `mem_rdata` are registered; there is no combinational input→output path.

## Configuration
- `MEM_JITTER_EN` defined:
  - an 8-bit Galois LFSR (taps 8,6,5,4), reset to `8'hA5`, advances on every sampled request;
  - its low 2 bits add 0..3 extra BUSY cycles to that request, so effective latency is `LATENCY`..`LATENCY`+3, deterministic from reset.
- `MEM_JITTER_EN` undefined: latency is exactly `LATENCY`, and no LFSR logic exists.

## Structure
- Shared package `mem_pkg` holds:
  - `LINE_W` = 128 and `LINE_ADDR_W` = 28;
  - the state enum {IDLE, BUSY, RESP};
  - the LFSR seed constant `8'hA5`.
- One sub-module, `mem_lfsr8`: the jitter LFSR, instantiated only under `MEM_JITTER_EN`.
- Counter width is `$clog2(LATENCY+4)`.

## Test plan
- **Reset then single read** (`LATENCY`=4, preloaded `array[5]` = `128'h0123…CDEF`): `mem_read`, `mem_addr`=5 in cycle 0 → `mem_ready`=1 only in cycle 4 with that data; 0 in cycles 1–3 and 5.
- **Write then read**: write `mem_addr`=`28'h0000012`, wdata all-`A5` → ready in cycle 4. Read the same address in cycle 5 → ready in cycle 9 with all-`A5`. Read of `28'h0000412` (alias, `DEPTH_LOG2`=10) → same data.
- **Cache-style write-back → refill**: write held until ready, then a read asserted the very next cycle → exactly two ready pulses, 5 cycles apart.
- **Request dropped after one cycle, and read+write together**: the dropped request still completes on time. Read+write together → write performed, `mem_rdata` unchanged.
- **Reset mid-operation**: `proc_reset` in cycle 2 of a write → no ready pulse and the array location keeps its old value. A subsequent read completes normally.
- **`MEM_JITTER_EN`**: 16 reads from reset → every latency in 4..7, and the sequence matches the LFSR reference from seed `8'hA5`.
